clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
- Sits directly downstream of the divide-by-2 stage and consumes its divided clock as a data signal in the source clock domain.
- Synchronises the divided clock and detects its rising and falling edges.
- Measures the period between rising edges in source-clock cycles and declares lock once the period matches an expected value.
- Flags mismatches and a stalled divided clock with a sticky error, for clock-health checking of divider outputs.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on div_clk (≥2).
- CNT_W, 8, width of the period counter and the period/exp_period buses.
- LOCK_CNT, 4, consecutive matching periods required to assert locked (1..15).
- TIMEOUT, 255, clk_in cycles without a rising edge before a stall is declared (2..2**CNT_W-1).

Ports:
- clk_in  input  1  sole clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- div_clk  input  1  divided clock under test, sampled as data.
- exp_period  input  CNT_W  expected period in clk_in cycles; sampled at each rising-edge event.
- err_clr  input  1  clears err (synchronous).
- rise_pulse  output  1  one-cycle pulse per div_clk rising edge.
- fall_pulse  output  1  one-cycle pulse per div_clk falling edge.
- period  output  CNT_W  last measured period; held between updates.
- period_valid  output  1  one-cycle pulse when period updates.
- locked  output  1  period stable and equal to exp_period.
- err  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous, rst_n=0): synchroniser chain, prev flop, counter, match count, all outputs = 0; state = IDLE.
- Synchroniser: SYNC_STAGES flops → s; prev <= s. Internal events: rise_ev = s & ~prev, fall_ev = ~s & prev.
- rise_pulse and fall_pulse are registered copies of rise_ev and fall_ev.
- Pulse latency: if div_clk changes before clk_in edge 0, the pulse is high from edge SYNC_STAGES to edge SYNC_STAGES+1.
- FSM states: IDLE, MEASURE, LOCKED.
- IDLE:
  - Counter held at 0; no timeout.
  - On rise_ev: cnt <= 0, state -> MEASURE, no period_valid.
- MEASURE and LOCKED:
  - cnt increments each cycle with no rise_ev.
  - On rise_ev: period <= cnt+1, period_valid pulses in the same cycle as rise_pulse, cnt <= 0.
- MEASURE, on rise_ev:
  - If cnt+1 == exp_period: match_cnt++.
  - Otherwise: match_cnt <= 0, no error.
  - When match_cnt reaches LOCK_CNT: state -> LOCKED; locked=1 from the same edge that raises period_valid.
- LOCKED, on rise_ev with cnt+1 != exp_period: err <= 1, locked <= 0, match_cnt <= 0, state -> MEASURE.
- Timeout (MEASURE or LOCKED):
  - If cnt+1 == TIMEOUT with no rise_ev: err <= 1, locked <= 0, cnt <= 0, match_cnt <= 0, state -> IDLE, no period_valid.
  - rise_ev in that same cycle wins: period = TIMEOUT, normal compare, no timeout.
- err is sticky. err_clr clears it on the next edge. A new error in the same cycle as err_clr wins (err stays 1).
- exp_period changed mid-lock takes effect at the next rise_ev compare.
- Arithmetic is unsigned. cnt never exceeds TIMEOUT-1, so cnt+1 fits CNT_W.
- A div_clk glitch shorter than one clk_in cycle may be missed; this is not an error by itself.
- Reset mid-operation returns all state and outputs to reset values immediately, with no clock needed.

Test Plan:
1. Reset: rst_n=0 for 12 ns with div_clk toggling -> all outputs 0 throughout; first rise_pulse no earlier than SYNC_STAGES edges after release.
2. Divide-by-2 stimulus (div_clk toggles every clk_in posedge), exp_period=2, LOCK_CNT=4:
   - first rise gives no period_valid;
   - subsequent period_valid pulses have period=2;
   - locked=1 with the 4th period_valid;
   - fall_pulse alternates with rise_pulse.
3. Divide-by-6 (3 high / 3 low), exp_period=6 -> period=6 and lock. Then switch to divide-by-4 -> first mismatched period_valid carries period=4, err=1, locked=0. Relock after 4 more periods with exp_period=4.
4. While locked, hold div_clk low -> exactly TIMEOUT (255) cycles after the last rise_ev: err=1, locked=0, no period_valid. Relock needs 1+LOCK_CNT rising edges.
5. err=1, pulse err_clr with no error present -> err=0 on the next edge. Pulse err_clr in the same cycle as a mismatch -> err remains 1.
6. Assert rst_n=0 asynchronously between clk_in edges while locked -> locked, err, period, and the pulses go 0 immediately. After release, behaviour matches scenario 2.

Source files
------------

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: clock-health monitor for a divided clock sampled as data in the source domain.
// Synchronises div_clk, emits rise/fall pulses, measures the rise-to-rise period,
// declares lock after LOCK_CNT consecutive periods equal to exp_period, and raises
// a sticky err on a mismatch while locked or on a stalled divided clock.
// Ports:
//   clk_in       - source clock, all logic on posedge
//   rst_n        - asynchronous active-low reset
//   div_clk      - divided clock under test (asynchronous data input)
//   exp_period   - expected period in clk_in cycles, sampled on each rising edge event
//   err_clr      - synchronous clear of err (a simultaneous new error wins)
//   rise_pulse   - one-cycle pulse per div_clk rising edge
//   fall_pulse   - one-cycle pulse per div_clk falling edge
//   period       - last measured period, held between updates
//   period_valid - one-cycle pulse when period updates
//   locked       - period stable and equal to exp_period
//   err          - sticky error flag
module clk_div_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             div_clk,
    input  logic [CNT_W-1:0] exp_period,
    input  logic             err_clr,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);

    localparam int unsigned MATCH_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 prev_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [CNT_W-1:0]     period_d;
    logic                 period_valid_d;
    logic                 locked_d;
    logic                 err_d;
    logic                 err_set;

    logic                 sync_out;
    logic                 rise_ev;
    logic                 fall_ev;
    logic [CNT_W-1:0]     cnt_inc;
    logic [MATCH_W-1:0]   match_inc;
    logic                 period_match;
    logic                 timeout_hit;

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign rise_ev      = sync_out & ~prev_q;
    assign fall_ev      = ~sync_out & prev_q;
    // cnt never exceeds TIMEOUT-1, so the increment cannot wrap
    assign cnt_inc      = cnt_q + CNT_W'(1);
    assign match_inc    = match_q + MATCH_W'(1);
    assign period_match = (cnt_inc == exp_period);
    assign timeout_hit  = (cnt_inc == CNT_W'(TIMEOUT));

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        match_d        = match_q;
        period_d       = period;
        period_valid_d = 1'b0;
        locked_d       = locked;
        err_set        = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise_ev) begin
                    match_d = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (rise_ev) begin
                    // A rising edge coinciding with the timeout still counts as a period
                    period_d       = cnt_inc;
                    period_valid_d = 1'b1;
                    cnt_d          = '0;
                    if (period_match) begin
                        if (state_q == MEASURE) begin
                            match_d = match_inc;
                            if (match_inc == MATCH_W'(LOCK_CNT)) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        match_d = '0;
                        if (state_q == LOCKED) begin
                            err_set  = 1'b1;
                            locked_d = 1'b0;
                            state_d  = MEASURE;
                        end
                    end
                end else if (timeout_hit) begin
                    err_set  = 1'b1;
                    locked_d = 1'b0;
                    cnt_d    = '0;
                    match_d  = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // New error takes priority over the clear
        err_d = err_set | (err & ~err_clr);
    end

    // State, synchroniser and output registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            match_q      <= '0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], div_clk};
            prev_q       <= sync_out;
            cnt_q        <= cnt_d;
            match_q      <= match_d;
            rise_pulse   <= rise_ev;
            fall_pulse   <= fall_ev;
            period       <= period_d;
            period_valid <= period_valid_d;
            locked       <= locked_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: self-checking bench for clk_div_monitor.
// Expected (period, locked, err) triples are queued as div_clk stimulus is driven
// and compared whenever the DUT pulses period_valid.
module tb_clk_div_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int LOCK_CNT    = 4;
    localparam int TIMEOUT     = 255;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic             locked;
        logic             err;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             div_clk;
    logic [CNT_W-1:0] exp_period;
    logic             err_clr;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             err;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_pv_cyc = 0;

    clk_div_monitor #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W),
        .LOCK_CNT   (LOCK_CNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_in      (clk),
        .rst_n       (rst_n),
        .div_clk     (div_clk),
        .exp_period  (exp_period),
        .err_clr     (err_clr),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every period_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && period_valid === 1'b1) begin
            last_pv_cyc = cyc;
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_pv: period_valid=1 period=%0d locked=%0b at cycle %0d, required no pulse",
                         period, locked, cyc);
            end else begin
                e = sb_q.pop_front();
                if ({period, locked, err, rise_pulse} !== {e.period, e.locked, e.err, 1'b1}) begin
                    miscompares++;
                    $display("FAIL sb_period: got period=%0d locked=%0b err=%0b rise=%0b, required period=%0d locked=%0b err=%0b rise=1",
                             period, locked, err, rise_pulse, e.period, e.locked, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void push_exp(input logic [CNT_W-1:0] p, input logic l, input logic e);
        exp_t x;
        x.period = p;
        x.locked = l;
        x.err    = e;
        sb_q.push_back(x);
    endfunction

    // Each iteration: one rising edge, hi cycles high then lo cycles low
    task automatic drive_period(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            div_clk = 1'b1;
            repeat (hi) @(negedge clk);
            div_clk = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        div_clk = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #2 div_clk = ~div_clk;
            vectors++;
            if ({rise_pulse, fall_pulse, period_valid, locked, err, period} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got rise=%0b fall=%0b pv=%0b locked=%0b err=%0b period=%0d, required all 0",
                         rise_pulse, fall_pulse, period_valid, locked, err, period);
            end
        end
        div_clk = 1'b1;
        rst_n   = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (rise_pulse === 1'b1) break;
        end
        vectors++;
        if (n != SYNC_STAGES + 1) begin
            miscompares++;
            $display("FAIL reset_first_rise: first rise_pulse after %0d edges, required %0d", n, SYNC_STAGES + 1);
        end
    endtask

    task automatic test_div2();
        exp_period = 8'd2;
        for (int i = 0; i < 6; i++) push_exp(8'd2, (i >= LOCK_CNT - 1) ? 1'b1 : 1'b0, 1'b0);
        fork
            drive_period(1, 1, 7);
            begin
                repeat (3) @(negedge clk);
                for (int j = 0; j < 13; j++) begin
                    vectors++;
                    if ({rise_pulse, fall_pulse} !== ((j % 2 == 0) ? 2'b10 : 2'b01)) begin
                        miscompares++;
                        $display("FAIL div2_alternate: step %0d got rise=%0b fall=%0b, required rise=%0b fall=%0b",
                                 j, rise_pulse, fall_pulse, (j % 2 == 0), (j % 2 != 0));
                    end
                    @(negedge clk);
                end
            end
        join
        wait_drain();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL div2_drain: %0d expected period_valid pulses missing, required 0", sb_q.size());
        end
    endtask

    task automatic test_div6_to_div4();
        exp_period = 8'd6;
        for (int i = 0; i < 6; i++) push_exp(8'd6, (i >= LOCK_CNT - 1) ? 1'b1 : 1'b0, 1'b0);
        push_exp(8'd4, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) push_exp(8'd4, (i == 3) ? 1'b1 : 1'b0, 1'b1);
        drive_period(3, 3, 6);
        drive_period(2, 2, 2);
        exp_period = 8'd4;
        drive_period(2, 2, 4);
        wait_drain();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL div6_div4_drain: %0d expected period_valid pulses missing, required 0", sb_q.size());
        end
    endtask

    task automatic test_err_clr();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_clr_pre: err=%0b, required 1", err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clr_clear: err=%0b, required 0", err);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int diff;
        seen = 1'b0;
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_pre_lock: locked=%0b, required 1", locked);
        end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (locked === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL timeout_seen: locked stayed 1 for 400 cycles, required drop after %0d", TIMEOUT);
        end else begin
            diff = cyc - last_pv_cyc;
            vectors++;
            if (diff != TIMEOUT) begin
                miscompares++;
                $display("FAIL timeout_cycles: lock dropped %0d cycles after last rise, required %0d", diff, TIMEOUT);
            end
            vectors++;
            if ({err, period_valid, period} !== {1'b1, 1'b0, 8'd4}) begin
                miscompares++;
                $display("FAIL timeout_flags: err=%0b pv=%0b period=%0d, required err=1 pv=0 period=4",
                         err, period_valid, period);
            end
        end
        for (int i = 0; i < LOCK_CNT; i++) push_exp(8'd4, (i == LOCK_CNT - 1) ? 1'b1 : 1'b0, 1'b1);
        drive_period(2, 2, 1 + LOCK_CNT);
        wait_drain();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_relock_drain: %0d expected period_valid pulses missing, required 0", sb_q.size());
        end
    endtask

    task automatic test_err_clr_collision();
        logic [CNT_W-1:0] per;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++;
        if ({err, locked} !== 2'b01) begin
            miscompares++;
            $display("FAIL collide_pre: err=%0b locked=%0b, required err=0 locked=1", err, locked);
        end
        // Impossible expectation forces a mismatch on the next rise while locked
        exp_period = 8'd1;
        per = CNT_W'(cyc + 3 - last_pv_cyc);
        push_exp(per, 1'b0, 1'b1);
        div_clk = 1'b1;
        repeat (2) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++;
        if ({err, locked} !== 2'b10) begin
            miscompares++;
            $display("FAIL collide_err: err=%0b locked=%0b, required err=1 locked=0", err, locked);
        end
        div_clk = 1'b0;
        wait_drain();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL collide_drain: %0d expected period_valid pulses missing, required 0", sb_q.size());
        end
    endtask

    task automatic test_async_reset();
        logic [CNT_W-1:0] per;
        exp_period = 8'd2;
        per = CNT_W'(cyc + 3 - last_pv_cyc);
        push_exp(per, 1'b0, 1'b1);
        for (int i = 0; i < LOCK_CNT; i++) push_exp(8'd2, (i == LOCK_CNT - 1) ? 1'b1 : 1'b0, 1'b1);
        drive_period(1, 1, 1 + LOCK_CNT);
        wait_drain();
        vectors++;
        if ({locked, err, period} !== {1'b1, 1'b1, 8'd2} || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL async_pre: locked=%0b err=%0b period=%0d pending=%0d, required locked=1 err=1 period=2 pending=0",
                     locked, err, period, sb_q.size());
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({rise_pulse, fall_pulse, period_valid, locked, err, period} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got rise=%0b fall=%0b pv=%0b locked=%0b err=%0b period=%0d, required all 0",
                     rise_pulse, fall_pulse, period_valid, locked, err, period);
        end
        @(negedge clk);
        div_clk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        test_div2();
    endtask

    initial begin
        rst_n      = 1'b1;
        div_clk    = 1'b0;
        err_clr    = 1'b0;
        exp_period = 8'd2;
        test_reset();
        apply_reset();
        test_div2();
        apply_reset();
        test_div6_to_div4();
        test_err_clr();
        test_timeout();
        test_err_clr_collision();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
